// File: rtl/bram_seq_ctrl.sv
// bram_seq_ctrl: sequences a run of word writes and/or reads over a single-port
// BRAM starting at a base address, with a read-latency pipeline that realigns
// returned data and an optional readback verify that counts pattern mismatches.
module bram_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_run,
  input  logic                  i_abort,
  input  logic [1:0]            i_mode,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_cnt,
  input  logic [DATA_WIDTH-1:0] i_seed,
  output logic                  o_idle,
  output logic                  o_write,
  output logic                  o_read,
  output logic                  o_done,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  en,
  output logic                  we,
  output logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] qout,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic [ADDR_WIDTH:0]   o_err_cnt,
  output logic                  o_pass
);

  localparam int CW = ADDR_WIDTH + 1;

  localparam logic [1:0] MODE_WRITE  = 2'b00;
  localparam logic [1:0] MODE_READ   = 2'b01;
  localparam logic [1:0] MODE_VERIFY = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [CW-1:0]         off_q, off_d;
  logic [2:0]            drain_q, drain_d;
  logic                  aborted_q, aborted_d;
  logic [CW-1:0]         err_q, err_d;
  logic                  pass_q, pass_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0] exp_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] exp_d [RD_LATENCY];

  logic                  last_off;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] pattern;
  logic                  rd_fire;
  logic                  beat_err;

  assign last_off = (off_q == cnt_q - 1'b1);
  assign cur_addr = base_q + off_q[ADDR_WIDTH-1:0];
  assign pattern  = seed_q + DATA_WIDTH'(off_q);

  assign o_valid    = vld_q[RD_LATENCY-1];
  assign o_mem_data = o_valid ? qout : '0;
  assign o_busy     = (state_q != S_IDLE);
  assign o_err_cnt  = err_q;
  assign o_pass     = pass_q;

  // Next-state, run bookkeeping and BRAM/flag outputs for the sequencer FSM.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    seed_d    = seed_q;
    off_d     = off_q;
    drain_d   = drain_q;
    aborted_d = aborted_q;
    pass_d    = pass_q;
    err_d     = (beat_err && (err_q != '1)) ? err_q + 1'b1 : err_q;
    o_idle    = 1'b0;
    o_write   = 1'b0;
    o_read    = 1'b0;
    o_done    = 1'b0;
    addr      = '0;
    en        = 1'b0;
    we        = 1'b0;
    din       = '0;
    rd_fire   = 1'b0;

    case (state_q)
      S_IDLE: begin
        o_idle = 1'b1;
        if (i_run && (i_cnt != '0)) begin
          mode_d    = i_mode;
          base_d    = i_base_addr;
          cnt_d     = i_cnt;
          seed_d    = i_seed;
          off_d     = '0;
          err_d     = '0;
          pass_d    = 1'b0;
          aborted_d = 1'b0;
          state_d   = (i_mode == MODE_READ) ? S_READ : S_WRITE;
        end
      end
      S_WRITE: begin
        o_write = 1'b1;
        addr    = cur_addr;
        en      = 1'b1;
        we      = 1'b1;
        din     = pattern;
        if (i_abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (last_off) begin
          off_d   = '0;
          state_d = (mode_q == MODE_WRITE) ? S_DONE : S_READ;
        end else begin
          off_d = off_q + 1'b1;
        end
      end
      S_READ: begin
        o_read  = 1'b1;
        addr    = cur_addr;
        en      = 1'b1;
        rd_fire = 1'b1;
        if (i_abort || last_off) begin
          aborted_d = aborted_q | i_abort;
          drain_d   = '0;
          state_d   = S_DRAIN;
        end else begin
          off_d = off_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == 3'(RD_LATENCY - 1)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        pass_d  = (mode_q == MODE_VERIFY) && !aborted_q && (err_q == '0);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read pipeline: valid and expected-pattern shift registers aligned to BRAM latency.
  always_comb begin
    vld_d    = vld_q;
    exp_d    = exp_q;
    vld_d[0] = rd_fire;
    exp_d[0] = pattern;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      exp_d[i] = exp_q[i-1];
    end
    beat_err = vld_q[RD_LATENCY-1] && (mode_q == MODE_VERIFY) &&
               (qout != exp_q[RD_LATENCY-1]);
  end

  // State, run context and pipeline registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      seed_q    <= '0;
      off_q     <= '0;
      drain_q   <= '0;
      aborted_q <= 1'b0;
      err_q     <= '0;
      pass_q    <= 1'b0;
      vld_q     <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        exp_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      seed_q    <= seed_d;
      off_q     <= off_d;
      drain_q   <= drain_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
      vld_q     <= vld_d;
      exp_q     <= exp_d;
    end
  end

endmodule

// File: tb/tb_bram_seq_ctrl.sv
// tb_bram_seq_ctrl: drives directed and randomized runs into bram_seq_ctrl with a
// latency-accurate BRAM model, and compares every write, read, data beat, timing
// and final status against a transaction-level reference computed per run.
module tb_bram_seq_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 12;
  localparam int LAT   = 3;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;

  logic          clk;
  logic          rst_n;
  logic          i_run;
  logic          i_abort;
  logic [1:0]    i_mode;
  logic [AW-1:0] i_base_addr;
  logic [CW-1:0] i_cnt;
  logic [DW-1:0] i_seed;
  logic          o_idle, o_write, o_read, o_done, o_busy;
  logic [AW-1:0] addr;
  logic          en, we;
  logic [DW-1:0] din;
  logic [DW-1:0] qout;
  logic          o_valid;
  logic [DW-1:0] o_mem_data;
  logic [CW-1:0] o_err_cnt;
  logic          o_pass;

  int nChecks = 0;
  int nFails  = 0;

  bram_seq_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RD_LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_run      (i_run),
    .i_abort    (i_abort),
    .i_mode     (i_mode),
    .i_base_addr(i_base_addr),
    .i_cnt      (i_cnt),
    .i_seed     (i_seed),
    .o_idle     (o_idle),
    .o_write    (o_write),
    .o_read     (o_read),
    .o_done     (o_done),
    .o_busy     (o_busy),
    .addr       (addr),
    .en         (en),
    .we         (we),
    .din        (din),
    .qout       (qout),
    .o_valid    (o_valid),
    .o_mem_data (o_mem_data),
    .o_err_cnt  (o_err_cnt),
    .o_pass     (o_pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: single port, LAT-cycle registered read, optional read corruption.
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] initImg [DEPTH];
  logic [DW-1:0] refMem  [DEPTH];
  logic [DW-1:0] rdPipe  [LAT];
  logic          fillMem;
  int            corruptAddr = -1;

  always @(posedge clk) begin
    if (fillMem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= initImg[i];
    end else if (en && we) begin
      mem[addr] <= din;
    end
    if (en && !we) rdPipe[0] <= mem[addr] ^ ((int'(addr) == corruptAddr) ? 8'h5A : 8'h00);
    for (int i = LAT - 1; i > 0; i--) rdPipe[i] <= rdPipe[i-1];
  end
  assign qout = rdPipe[LAT-1];

  // Observed transactions of the current run, tagged with cycle offset from accept.
  int gotWrA[$], gotWrD[$], gotRdA[$], gotRdT[$], gotVD[$], gotVT[$], gotDoneT[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One run: abortPhase 0 none, 1 abort at write offset abortK, 2 abort at read offset abortK.
  task automatic applyStimulus(input logic [1:0] mode, input int base, input int cnt,
                               input logic [7:0] seed, input int abortPhase, input int abortK,
                               input int corrupt, input bit pokeRun);
    bit hasWrite, hasRead, aborted, expPass;
    int nWr, nRd, rStart, doneT, abortT, expErr, wrFlags, rdFlags;
    int expWrA[$], expWrD[$], expRdA[$], expVD[$];
    logic sIdle, sPass;
    logic [CW-1:0] sErr;
    int a;
    logic [DW-1:0] d;

    hasWrite = (mode != 2'b01);
    hasRead  = (mode != 2'b00);
    aborted  = (abortPhase != 0);
    rStart   = hasWrite ? cnt : 0;
    nWr      = hasWrite ? ((abortPhase == 1) ? abortK + 1 : cnt) : 0;
    nRd      = (hasRead && abortPhase != 1) ? ((abortPhase == 2) ? abortK + 1 : cnt) : 0;
    if (abortPhase == 1)  doneT = abortK + 1;
    else if (nRd > 0)     doneT = rStart + nRd + LAT;
    else                  doneT = cnt;
    abortT = (abortPhase == 1) ? abortK : (abortPhase == 2) ? rStart + abortK : -1;

    for (int k = 0; k < nWr; k++) begin
      a = (base + k) % DEPTH;
      d = DW'(seed + k);
      expWrA.push_back(a);
      expWrD.push_back(int'(d));
      refMem[a] = d;
    end
    expErr = 0;
    for (int k = 0; k < nRd; k++) begin
      a = (base + k) % DEPTH;
      d = refMem[a] ^ ((a == corrupt) ? 8'h5A : 8'h00);
      expRdA.push_back(a);
      expVD.push_back(int'(d));
      if (mode == 2'b11 && d != DW'(seed + k)) expErr++;
    end
    expPass = (mode == 2'b11) && !aborted && (expErr == 0);

    gotWrA.delete(); gotWrD.delete(); gotRdA.delete(); gotRdT.delete();
    gotVD.delete(); gotVT.delete(); gotDoneT.delete();
    wrFlags = 0; rdFlags = 0;
    sIdle = 1'b0; sPass = 1'b0; sErr = '0;
    corruptAddr = corrupt;

    @(posedge clk); #1;
    i_mode = mode; i_base_addr = AW'(base); i_cnt = CW'(cnt); i_seed = seed; i_run = 1'b1;
    @(posedge clk); #1;
    i_run = 1'b0;
    i_mode = 2'($urandom); i_base_addr = AW'($urandom); i_cnt = CW'($urandom_range(1, 100));
    i_seed = DW'($urandom);
    for (int t = 0; t <= doneT + 1; t++) begin
      i_abort = (t == abortT);
      i_run   = pokeRun && (t == 1);
      @(negedge clk);
      if (t == 0) begin
        checkOutput("passClearedOnAccept", 32'(o_pass), 32'd0);
        checkOutput("busyAfterAccept", 32'(o_busy), 32'd1);
      end
      if (en && we) begin gotWrA.push_back(int'(addr)); gotWrD.push_back(int'(din)); end
      if (en && !we) begin gotRdA.push_back(int'(addr)); gotRdT.push_back(t); end
      if (o_valid) begin gotVD.push_back(int'(o_mem_data)); gotVT.push_back(t); end
      if (o_done) gotDoneT.push_back(t);
      if (o_write) wrFlags++;
      if (o_read) rdFlags++;
      if (t == doneT + 1) begin sIdle = o_idle; sErr = o_err_cnt; sPass = o_pass; end
      @(posedge clk); #1;
    end
    i_abort = 1'b0;
    i_run   = 1'b0;

    checkOutput("writeCount", 32'(gotWrA.size()), 32'(nWr));
    for (int k = 0; k < nWr && k < gotWrA.size(); k++) begin
      checkOutput($sformatf("wrAddr[%0d]", k), 32'(gotWrA[k]), 32'(expWrA[k]));
      checkOutput($sformatf("wrData[%0d]", k), 32'(gotWrD[k]), 32'(expWrD[k]));
    end
    checkOutput("readCount", 32'(gotRdA.size()), 32'(nRd));
    for (int k = 0; k < nRd && k < gotRdA.size(); k++) begin
      checkOutput($sformatf("rdAddr[%0d]", k), 32'(gotRdA[k]), 32'(expRdA[k]));
      checkOutput($sformatf("rdCycle[%0d]", k), 32'(gotRdT[k]), 32'(rStart + k));
    end
    checkOutput("validCount", 32'(gotVD.size()), 32'(nRd));
    for (int k = 0; k < nRd && k < gotVD.size(); k++) begin
      checkOutput($sformatf("validData[%0d]", k), 32'(gotVD[k]), 32'(expVD[k]));
      checkOutput($sformatf("validCycle[%0d]", k), 32'(gotVT[k]), 32'(rStart + k + LAT));
    end
    checkOutput("doneCount", 32'(gotDoneT.size()), 32'd1);
    if (gotDoneT.size() > 0) checkOutput("doneCycle", 32'(gotDoneT[0]), 32'(doneT));
    checkOutput("writeFlagCycles", 32'(wrFlags), 32'(nWr));
    checkOutput("readFlagCycles", 32'(rdFlags), 32'(nRd));
    checkOutput("idleAfterDone", 32'(sIdle), 32'd1);
    checkOutput("errCnt", 32'(sErr), 32'(expErr));
    checkOutput("pass", 32'(sPass), 32'(expPass));
  endtask

  // Reset asserted during a WRITE phase, then a zero-count run that must be ignored.
  task automatic resetMidRun();
    int base;
    logic [7:0] seed;
    base = $urandom_range(0, DEPTH - 1);
    seed = 8'($urandom);
    corruptAddr = -1;
    @(posedge clk); #1;
    i_mode = 2'b10; i_base_addr = AW'(base); i_cnt = CW'(20); i_seed = seed; i_run = 1'b1;
    @(posedge clk); #1;
    i_run = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) refMem[(base + k) % DEPTH] = DW'(seed + k);
    checkOutput("rstMid_idle", 32'(o_idle), 32'd1);
    checkOutput("rstMid_write", 32'(o_write), 32'd0);
    checkOutput("rstMid_en", 32'(en), 32'd0);
    checkOutput("rstMid_we", 32'(we), 32'd0);
    checkOutput("rstMid_valid", 32'(o_valid), 32'd0);
    checkOutput("rstMid_busy", 32'(o_busy), 32'd0);
    checkOutput("rstMid_done", 32'(o_done), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    i_mode = 2'b00; i_cnt = '0; i_run = 1'b1;
    @(posedge clk); #1;
    i_run = 1'b0; i_cnt = CW'(5);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      checkOutput($sformatf("zeroCnt_idle[%0d]", t), 32'(o_idle), 32'd1);
      checkOutput($sformatf("zeroCnt_en[%0d]", t), 32'(en), 32'd0);
    end
  endtask

  initial begin
    int mode, base, cnt, ph, k, cor, r;
    rst_n = 1'b0; i_run = 1'b0; i_abort = 1'b0; i_mode = '0;
    i_base_addr = '0; i_cnt = '0; i_seed = '0; fillMem = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      initImg[i] = DW'($urandom);
      refMem[i]  = initImg[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_idle", 32'(o_idle), 32'd1);
    checkOutput("reset_busy", 32'(o_busy), 32'd0);
    checkOutput("reset_en", 32'(en), 32'd0);
    checkOutput("reset_we", 32'(we), 32'd0);
    checkOutput("reset_valid", 32'(o_valid), 32'd0);
    checkOutput("reset_err", 32'(o_err_cnt), 32'd0);
    checkOutput("reset_pass", 32'(o_pass), 32'd0);
    checkOutput("reset_addr", 32'(addr), 32'd0);
    fillMem = 1'b0;
    #2 rst_n = 1'b1;

    $display("[TB] directed runs");
    applyStimulus(2'b10, 0, 4, 8'h10, 0, 0, -1, 1'b0);
    applyStimulus(2'b00, 12'hFFE, 4, 8'h37, 0, 0, -1, 1'b1);
    applyStimulus(2'b11, 0, 8, 8'hA0, 0, 0, 2, 1'b0);
    applyStimulus(2'b11, 0, 8, 8'hA0, 0, 0, -1, 1'b0);
    resetMidRun();
    applyStimulus(2'b01, 0, 5, 8'h00, 0, 0, -1, 1'b0);
    applyStimulus(2'b10, 100, 10, 8'h5C, 2, 2, -1, 1'b1);
    applyStimulus(2'b11, 200, 10, 8'h01, 1, 4, -1, 1'b1);
    applyStimulus(2'b11, 4000, 10, 8'hFA, 2, 9, -1, 1'b0);
    applyStimulus(2'b11, 1234, DEPTH, 8'h3C, 0, 0, -1, 1'b0);

    $display("[TB] randomized runs");
    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 3);
      base = $urandom_range(0, DEPTH - 1);
      cnt  = $urandom_range(1, 48);
      ph = 0; k = 0;
      r = $urandom_range(0, 3);
      if (r == 0 && mode != 1) begin ph = 1; k = $urandom_range(0, cnt - 1); end
      if (r == 1 && mode != 0) begin ph = 2; k = $urandom_range(0, cnt - 1); end
      cor = ($urandom_range(0, 2) == 0) ? (base + $urandom_range(0, cnt - 1)) % DEPTH : -1;
      applyStimulus(2'(mode), base, cnt, 8'($urandom), ph, k, cor, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
